// File: rtl/reg_write_arbiter_if.sv
// Bundle of request/grant/data and shared-register signals between producers
// and the register write arbiter.
interface reg_write_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) ();
    logic [N_REQ-1:0]         req;
    logic [N_REQ-1:0]         lock;
    logic [N_REQ*WIDTH-1:0]   data;
    logic [N_REQ-1:0]         gnt;
    logic [WIDTH-1:0]         q;
    logic [$clog2(N_REQ)-1:0] q_src;
    logic                     q_upd;
    logic                     busy;

    modport master (
        output req, lock, data,
        input  gnt, q, q_src, q_upd, busy
    );

    modport slave (
        input  req, lock, data,
        output gnt, q, q_src, q_upd, busy
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting one requester per cycle the right to load a
// shared register, with an optional bounded burst lock for the current owner.
module reg_write_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input logic              clk,
    input logic              rst_n,
    reg_write_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner;
    logic [CNT_W-1:0]   beat_cnt;
    logic [IDX_W-1:0]   sel;
    logic [N_REQ-1:0]   gnt_c;
    logic               found;
    logic               accept;
    int                 scan_idx;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (int'(i) == N_REQ - 1) ? '0 : i + IDX_W'(1);
    endfunction

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        gnt_c    = '0;
        sel      = owner;
        found    = 1'b0;
        scan_idx = 0;
        if (state == BURST) begin
            if (bus.req[owner]) gnt_c[owner] = 1'b1;
        end else begin
            // Scan from ptr upward with wrap; the first hit wins.
            for (int k = 0; k < N_REQ; k++) begin
                scan_idx = (int'(ptr) + k) % N_REQ;
                if (!found && bus.req[scan_idx]) begin
                    found           = 1'b1;
                    gnt_c[scan_idx] = 1'b1;
                    sel             = IDX_W'(scan_idx);
                end
            end
        end
    end

    assign accept  = |gnt_c;
    assign bus.gnt = rst_n ? gnt_c : '0;

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            beat_cnt  <= '0;
            bus.q     <= '0;
            bus.q_src <= '0;
            bus.q_upd <= 1'b0;
            bus.busy  <= 1'b0;
        end else begin
            bus.q_upd <= accept;
            if (accept) begin
                bus.q     <= bus.data[int'(sel)*WIDTH +: WIDTH];
                bus.q_src <= sel;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bus.lock[sel] && MAX_BURST > 1) begin
                            owner    <= sel;
                            beat_cnt <= CNT_W'(1);
                            state    <= BURST;
                            bus.busy <= 1'b1;
                        end else begin
                            ptr <= next_idx(sel);
                        end
                    end
                end
                BURST: begin
                    if (accept && bus.lock[owner] && (int'(beat_cnt) + 1 < MAX_BURST)) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end else begin
                        // Lock released, cap reached, or owner went quiet: hand on.
                        ptr      <= next_idx(owner);
                        beat_cnt <= '0;
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Randomized and directed bench for reg_write_arbiter against a rule-level
// reference model of the round-robin/burst ownership behaviour.
module tb_reg_write_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    reg_write_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    reg_write_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: who has priority, who owns a burst, how many beats taken.
    int         m_ptr;
    int         m_owner;
    int         m_beats;
    logic [W-1:0] m_q;
    int         m_src;
    logic       m_upd;
    logic       m_busy;

    task automatic model_reset();
        m_ptr = 0; m_owner = -1; m_beats = 0;
        m_q = '0; m_src = 0; m_upd = 1'b0; m_busy = 1'b0;
    endtask

    function automatic int model_winner(input logic [N-1:0] r);
        if (m_owner >= 0) return r[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++)
            if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_clock(input logic [N-1:0] r, input logic [N-1:0] l,
                               input logic [N*W-1:0] d);
        int w;
        w = model_winner(r);
        m_upd = (w >= 0);
        if (w >= 0) begin
            m_q   = d[w*W +: W];
            m_src = w;
            if (m_owner < 0) begin
                if (l[w] && MB > 1) begin
                    m_owner = w; m_beats = 1;
                end else begin
                    m_ptr = (w + 1) % N;
                end
            end else begin
                m_beats++;
                if (!l[w] || m_beats == MB) begin
                    m_ptr = (w + 1) % N; m_owner = -1; m_beats = 0;
                end
            end
        end else if (m_owner >= 0) begin
            m_ptr = (m_owner + 1) % N; m_owner = -1; m_beats = 0;
        end
        m_busy = (m_owner >= 0);
    endtask

    // Drives one cycle from posedge+1, samples gnt before the edge, advances the model.
    task automatic apply(input logic [N-1:0] r, input logic [N-1:0] l,
                         input logic [N*W-1:0] d,
                         output logic [N-1:0] g_obs, output logic [N-1:0] g_exp);
        int w;
        bus.req = r; bus.lock = l; bus.data = d;
        #1;
        g_obs = bus.gnt;
        w = model_winner(r);
        g_exp = (w >= 0) ? N'(1) << w : '0;
        @(posedge clk);
        model_clock(r, l, d);
        #1;
    endtask

    task automatic do_reset();
        bus.req = '0; bus.lock = '0; bus.data = '0;
        rst_n = 1'b0;
        #3;
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0]   go, ge;
    logic [N*W-1:0] dd;

    task automatic test_reset();
        bus.req = 4'b1111; bus.lock = '0; bus.data = 32'hdeadbeef;
        rst_n = 1'b0;
        #3;
        total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b expected 0000", bus.gnt); end
        total++; if (bus.q !== 8'h00) begin bad++; $display("FAIL reset_q: got %h expected 00", bus.q); end
        total++; if (bus.q_src !== 2'd0) begin bad++; $display("FAIL reset_q_src: got %0d expected 0", bus.q_src); end
        total++; if (bus.q_upd !== 1'b0) begin bad++; $display("FAIL reset_q_upd: got %b expected 0", bus.q_upd); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        @(negedge clk) begin rst_n = 1'b1; bus.req = '0; end
        model_reset();
        @(posedge clk);
        #1;
        apply(4'b1111, 4'b0000, 32'h13121110, go, ge);
        total++; if (go !== 4'b0001) begin bad++; $display("FAIL reset_first_gnt: got %b expected 0001", go); end
    endtask

    task automatic test_round_robin();
        do_reset();
        dd = 32'h13121110;
        for (int i = 0; i < N; i++) begin
            apply(4'b1111, 4'b0000, dd, go, ge);
            total++; if (go !== ge) begin bad++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, go, ge); end
            total++; if (bus.q !== m_q) begin bad++; $display("FAIL rr_q[%0d]: got %h expected %h", i, bus.q, m_q); end
            total++; if (bus.q_upd !== 1'b1) begin bad++; $display("FAIL rr_q_upd[%0d]: got %b expected 1", i, bus.q_upd); end
        end
    endtask

    task automatic test_wrap_skip();
        do_reset();
        apply(4'b0100, 4'b0000, 32'h0, go, ge); // moves priority to requester 3
        apply(4'b0101, 4'b0000, 32'h00aa00bb, go, ge);
        total++; if (go !== ge) begin bad++; $display("FAIL wrap_gnt0: got %b expected %b", go, ge); end
        apply(4'b0101, 4'b0000, 32'h00aa00bb, go, ge);
        total++; if (go !== ge) begin bad++; $display("FAIL wrap_gnt2: got %b expected %b", go, ge); end
        total++; if (bus.q_src !== 2'(m_src)) begin bad++; $display("FAIL wrap_q_src: got %0d expected %0d", bus.q_src, m_src); end
        apply(4'b1111, 4'b0000, 32'h0, go, ge);
        total++; if (go !== ge) begin bad++; $display("FAIL wrap_ptr3: got %b expected %b", go, ge); end
    endtask

    task automatic test_burst_cap();
        do_reset();
        for (int i = 0; i < MB + 1; i++) begin
            apply(4'b0011, 4'b0001, 32'h0000_2a00 + 32'(i), go, ge);
            total++; if (go !== ge) begin bad++; $display("FAIL cap_gnt[%0d]: got %b expected %b", i, go, ge); end
            total++; if (bus.busy !== m_busy) begin bad++; $display("FAIL cap_busy[%0d]: got %b expected %b", i, bus.busy, m_busy); end
            total++; if (bus.q !== m_q) begin bad++; $display("FAIL cap_q[%0d]: got %h expected %h", i, bus.q, m_q); end
        end
    endtask

    task automatic test_burst_early();
        do_reset();
        apply(4'b0011, 4'b0001, 32'h0000_5150, go, ge);
        apply(4'b0011, 4'b0000, 32'h0000_5352, go, ge);
        total++; if (bus.q !== m_q) begin bad++; $display("FAIL early_q: got %h expected %h", bus.q, m_q); end
        apply(4'b0011, 4'b0000, 32'h0000_5554, go, ge);
        total++; if (go !== ge) begin bad++; $display("FAIL early_gnt: got %b expected %b", go, ge); end
        do_reset();
        apply(4'b0001, 4'b0001, 32'h0000_0077, go, ge);
        apply(4'b0010, 4'b0000, 32'h0000_6600, go, ge);
        total++; if (go !== ge) begin bad++; $display("FAIL bubble_gnt: got %b expected %b", go, ge); end
        total++; if (bus.q !== m_q) begin bad++; $display("FAIL bubble_q: got %h expected %h", bus.q, m_q); end
        total++; if (bus.q_upd !== m_upd) begin bad++; $display("FAIL bubble_q_upd: got %b expected %b", bus.q_upd, m_upd); end
        apply(4'b0010, 4'b0000, 32'h0000_6600, go, ge);
        total++; if (go !== ge) begin bad++; $display("FAIL post_bubble_gnt: got %b expected %b", go, ge); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        apply(4'b0001, 4'b0001, 32'h0000_00c1, go, ge);
        apply(4'b0001, 4'b0001, 32'h0000_00c2, go, ge);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mid_busy_pre: got %b expected 1", bus.busy); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b expected 0", bus.busy); end
        total++; if (bus.q !== 8'h00) begin bad++; $display("FAIL mid_q: got %h expected 00", bus.q); end
        total++; if (bus.q_upd !== 1'b0) begin bad++; $display("FAIL mid_q_upd: got %b expected 0", bus.q_upd); end
        @(negedge clk) begin rst_n = 1'b1; bus.req = '0; end
        model_reset();
        @(posedge clk);
        #1;
        apply(4'b1111, 4'b0000, 32'h0, go, ge);
        total++; if (go !== ge) begin bad++; $display("FAIL mid_restart_gnt: got %b expected %b", go, ge); end
    endtask

    task automatic test_random();
        logic [N-1:0] r, l;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r  = N'($urandom_range(0, 15));
            l  = (i % 64 < 32) ? N'($urandom) : N'($urandom) & N'($urandom);
            dd = $urandom;
            apply(r, l, dd, go, ge);
            total++; if (go !== ge) begin bad++; $display("FAIL rnd_gnt[%0d]: got %b expected %b", i, go, ge); end
            total++; if ((go & ~r) !== '0 || !$onehot0(go)) begin bad++; $display("FAIL rnd_gnt_legal[%0d]: got %b req %b", i, go, r); end
            total++; if (bus.q !== m_q) begin bad++; $display("FAIL rnd_q[%0d]: got %h expected %h", i, bus.q, m_q); end
            total++; if (bus.q_src !== 2'(m_src)) begin bad++; $display("FAIL rnd_q_src[%0d]: got %0d expected %0d", i, bus.q_src, m_src); end
            total++; if (bus.q_upd !== m_upd) begin bad++; $display("FAIL rnd_q_upd[%0d]: got %b expected %b", i, bus.q_upd, m_upd); end
            total++; if (bus.busy !== m_busy) begin bad++; $display("FAIL rnd_busy[%0d]: got %b expected %b", i, bus.busy, m_busy); end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        bus.req = '0; bus.lock = '0; bus.data = '0;
        model_reset();
        #2;
        test_reset();
        test_round_robin();
        test_wrap_skip();
        test_burst_cap();
        test_burst_early();
        test_reset_mid_burst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
